// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The op_sub field exists only when NSA_SUB_EN is defined.
interface nibble_serial_adder_if #(
    parameter int N_NIBBLES = 4
) ();
    localparam int W = 4 * N_NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
`ifdef NSA_SUB_EN
    logic         op_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

`ifdef NSA_SUB_EN
    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, op_a, op_b, op_cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-nibble add sequencer driving an external 4-bit adder, LSB nibble first.
// Define NSA_SUB_EN to add subtraction (op_sub) support.
module nibble_serial_adder #(
    parameter int N_NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_serial_adder_if.slave         bus,
    output logic [3:0]                   add_a,
    output logic [3:0]                   add_b,
    output logic                         add_cin,
    input  logic [3:0]                   add_s,
    input  logic                         add_cout
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = $clog2(N_NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic [W-1:0]       b_load_s;
    logic               cin_load_s;
    logic               last_s;
    logic               run_s;

    // Operand conditioning at accept: subtraction is A + ~B + 1
    always_comb begin
        b_load_s   = bus.op_b;
        cin_load_s = bus.op_cin;
`ifdef NSA_SUB_EN
        if (bus.op_sub) begin
            b_load_s   = ~bus.op_b;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = bus.op_b;
            cin_load_s = bus.op_cin;
        end
`endif
    end

    assign last_s = (idx_r == IDX_W'(N_NIBBLES - 1));

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, operand shift registers, carry and result accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.op_a;
                        b_r     <= b_load_s;
                        carry_r <= cin_load_s;
                        idx_r   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= add_s;
                    carry_r <= add_cout;
                    a_r     <= a_r >> 4;
                    b_r     <= b_r >> 4;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout_r <= add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Adder stimulus comes only from flops, so add_s/add_cout never loop back combinationally
    assign run_s         = rst_n && (state_r == ST_RUN);
    assign add_a         = run_s ? a_r[3:0] : 4'b0000;
    assign add_b         = run_s ? b_r[3:0] : 4'b0000;
    assign add_cin       = run_s ? carry_r  : 1'b0;

    assign bus.in_ready  = rst_n && (state_r == ST_IDLE);
    assign bus.out_valid = rst_n && (state_r == ST_DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with a behavioural 4-bit adder
// and an arithmetic reference model (N_NIBBLES=4).
module tb_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_s;
    logic       add_cin;
    logic       add_cout;
    int         total = 0;
    int         bad   = 0;

    nibble_serial_adder_if #(.N_NIBBLES(N)) bus ();

    nibble_serial_adder #(.N_NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // External 4-bit adder stage
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: accept, per-nibble adder drive, result, optional hold, handshake
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int hold);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   expv;
        int           mask;
        int           cy;
        bb   = sub ? ~b : b;
        c0   = sub ? 1'b1 : cin;
        expv = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        for (int i = 0; i < 10 && !bus.in_ready; i++) tick();
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
`ifdef NSA_SUB_EN
        bus.op_sub   = sub;
`endif
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            mask = (1 << (4 * k)) - 1;
            cy   = ((int'(a) & mask) + (int'(bb) & mask) + int'(c0)) >> (4 * k);
            check("run_add_a",   32'(add_a), (int'(a)  >> (4 * k)) & 15);
            check("run_add_b",   32'(add_b), (int'(bb) >> (4 * k)) & 15);
            check("run_add_cin", 32'(add_cin), 32'(cy));
            check("run_out_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        check("done_out_valid", 32'(bus.out_valid), 32'd1);
        check("done_sum",  32'(bus.sum),  32'(expv[W-1:0]));
        check("done_cout", 32'(bus.cout), 32'(expv[W]));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = (h == 1);
            bus.op_a     = W'($urandom);
            bus.op_b     = W'($urandom);
            tick();
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
            check("hold_sum",  32'(bus.sum),  32'(expv[W-1:0]));
            check("hold_cout", 32'(bus.cout), 32'(expv[W]));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ack_out_valid", 32'(bus.out_valid), 32'd0);
        check("ack_in_ready",  32'(bus.in_ready),  32'd1);
        check("ack_sum_kept",  32'(bus.sum), 32'(expv[W-1:0]));
        check("idle_add_a",    32'(add_a), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef NSA_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_add", {23'd0, add_a, add_b, add_cin}, 32'd0);

        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hA5C3, 16'h5A3C, 1'b1, 1'b0, 5);

        // Reset abort while idx==2
        ra = W'($urandom);
        rb = W'($urandom);
        bus.in_valid = 1'b1;
        bus.op_a     = ra;
        bus.op_b     = rb;
        bus.op_cin   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("abort_at_idx2", 32'(add_a), 32'(ra[11:8]));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sum",  32'(bus.sum),  32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1);

`ifdef NSA_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int r = 0; r < 20; r++) begin
            logic sub_r;
            sub_r = 1'b0;
`ifdef NSA_SUB_EN
            sub_r = 1'($urandom);
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sub_r, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
